intra_ram_arb_ctl: RTL and testbench
====================================

Name: intra_ram_arb_ctl

Overview:
- Controller for port A of the 32x64 dual-port intra RAM. Port B is untouched.
- Shares port A between two requesters with round-robin arbitration:
  - write requester: intra reconstruction write-back;
  - read requester: intra neighbour fetch.
- Also provides a clear sequencer that fills all 64 words with CLR_VALUE at CTU/tile start.
- Sits between the intra prediction/reconstruction engines and the RAM wrapper. Drives the RAM's active-low cen/oen/wen controls.

Parameters:
- ADDR_WIDTH, 6, RAM address width (depth = 2^ADDR_WIDTH = 64)
- WORD_WIDTH, 32, RAM word width
- CLR_VALUE, 0, word written to every address during clear

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr_start_i  in  1  one-cycle pulse: start clear sweep
- clr_busy_o  out  1  high while clear sweep in progress
- wr_req_i  in  1  write request; held with addr/data until wr_ack_o
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  WORD_WIDTH  write data
- wr_ack_o  out  1  write accepted this cycle (combinational)
- rd_req_i  in  1  read request; held with addr until rd_ack_o
- rd_addr_i  in  ADDR_WIDTH  read address
- rd_ack_o  out  1  read issued to RAM this cycle (combinational)
- rd_valid_o  out  1  read data valid, one cycle after rd_ack_o
- rd_data_o  out  WORD_WIDTH  read data; 0 when rd_valid_o low
- ram_cen_o  out  1  RAM chip enable, active low
- ram_oen_o  out  1  RAM output enable, active low; constant 0
- ram_wen_o  out  1  RAM write enable, active low
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_data_o  out  WORD_WIDTH  RAM write data
- ram_data_i  in  WORD_WIDTH  RAM read data; valid the cycle after a read access

Behaviour:
- Single clock clk. Asynchronous active-low reset rst_n. All flops reset asynchronously.
- While rst_n is low, all outputs are forced to their reset values:
  - wr_ack_o=0, rd_ack_o=0, rd_valid_o=0, rd_data_o=0, clr_busy_o=0
  - ram_cen_o=1, ram_wen_o=1, ram_oen_o=0, ram_addr_o=0, ram_data_o=0
- Internal reset state: FSM=SERVE, clr_cnt=0, rr_last=RD (next tie goes to write), rd_pend=0.
- FSM states: SERVE, CLEAR.
  - SERVE -> CLEAR on clr_start_i=1, which also sets clr_cnt=0. In that same cycle no ack is issued and the RAM is idle.
  - CLEAR -> SERVE after the cycle in which clr_cnt=2^ADDR_WIDTH-1 is written.
  - clr_start_i is ignored while in CLEAR.
- CLEAR behaviour:
  - One write per cycle: ram_cen_o=0, ram_wen_o=0, ram_addr_o=clr_cnt, ram_data_o=CLR_VALUE.
  - clr_cnt increments each cycle.
  - clr_busy_o=1 for exactly 64 cycles.
  - No acks are issued; requesters keep holding.
- SERVE arbitration (combinational grant):
  - Only wr_req_i: grant write. Only rd_req_i: grant read.
  - Both: grant the one not equal to rr_last. rr_last updates on every grant.
  - No request: ram_cen_o=1, ram_wen_o=1. Address and data hold their last value; only the enables matter.
- Write grant: wr_ack_o=1, ram_cen_o=0, ram_wen_o=0, ram_addr_o=wr_addr_i, ram_data_o=wr_data_i.
- Read grant:
  - rd_ack_o=1, ram_cen_o=0, ram_wen_o=1, ram_addr_o=rd_addr_i.
  - rd_pend is registered to 1; next cycle rd_valid_o=1 and rd_data_o=ram_data_i.
  - Back-to-back reads give one valid per cycle.
- Throughput: one access per cycle. Under continuous dual request the grants alternate W,R,W,R.
- Same-address collision: a write acked in cycle N followed by a read of that address acked in N+1 returns the new data, because RAM writes complete at the N edge.
- Reset mid-clear aborts the sweep. After reset release the FSM is in SERVE and the RAM contents are undefined.
- A requester dropping req before its ack is legal; no access occurs.

Decomposition:
- Shared package/defines (enc_defines):
  - INTRA_RAM_AW=6, INTRA_RAM_WW=32
  - FSM state encodings: SERVE=1'b0, CLEAR=1'b1
  - requester id encodings: WR=0, RD=1
- One natural sub-module: intra_rr_arb2, a 2-input round-robin arbiter holding the rr_last flop. FSM, counter and RAM muxing stay in the top.

Test Plan:
- Reset, then clr_start_i pulse:
  - clr_busy_o high for exactly 64 cycles;
  - ram_addr_o sweeps 0..63 with ram_wen_o=0, ram_data_o=0;
  - reading addr 37 afterwards returns 0x00000000.
- Write then read:
  - write 0xDEADBEEF to addr 5 (wr_ack_o same cycle);
  - read addr 5 next cycle;
  - rd_valid_o one cycle after rd_ack_o, with rd_data_o=0xDEADBEEF.
- Simultaneous held requests for 6 cycles from reset: grant order W,R,W,R,W,R; never two acks in one cycle.
- Request during clear:
  - wr_req_i held from clear cycle 10;
  - no wr_ack_o until the cycle after clr_busy_o falls;
  - no clear write is skipped.
- rst_n asserted at clear cycle 20:
  - outputs go to reset values immediately;
  - after release clr_busy_o=0 and a read request is acked in the first cycle.
- Back-to-back reads of addrs 0,1,2 after writing 0x11,0x22,0x33: rd_valid_o high three consecutive cycles with data 0x11,0x22,0x33.

Source files
------------

// File: rtl/intra_ram_arb_ctl_pkg.sv
// ----------------------------------------------------------------------------
// intra_ram_arb_ctl_pkg
//   Shared definitions for the intra RAM port-A controller: RAM geometry,
//   controller FSM state encoding and requester id encoding.
// ----------------------------------------------------------------------------
package intra_ram_arb_ctl_pkg;

    localparam int INTRA_RAM_AW = 6;   // address width, depth = 64 words
    localparam int INTRA_RAM_WW = 32;  // word width

    typedef enum logic {
        ST_SERVE = 1'b0,  // arbitrate between write-back and neighbour fetch
        ST_CLEAR = 1'b1   // sweep every address with the clear value
    } ctl_state_e;

    typedef enum logic {
        REQ_WR = 1'b0,    // intra reconstruction write-back
        REQ_RD = 1'b1     // intra neighbour fetch
    } req_id_e;

endpackage

// File: rtl/intra_rr_arb2.sv
// ----------------------------------------------------------------------------
// intra_rr_arb2
//   Two-input round-robin arbiter. The grant is combinational; the flop
//   remembers which requester won last so that a tie goes to the other one.
//   After reset a tie goes to the write requester.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en_i         grants allowed this cycle
//   req_wr_i     write requester asks for the port
//   req_rd_i     read requester asks for the port
//   gnt_wr_o     write requester owns the port this cycle
//   gnt_rd_o     read requester owns the port this cycle
// ----------------------------------------------------------------------------
module intra_rr_arb2
    import intra_ram_arb_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    req_id_e rr_last;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        gnt_wr_o = 1'b0;
        gnt_rd_o = 1'b0;
        if (en_i) begin
            if (req_wr_i && req_rd_i) begin
                if (rr_last == REQ_RD) begin
                    gnt_wr_o = 1'b1;
                end else begin
                    gnt_rd_o = 1'b1;
                end
            end else begin
                gnt_wr_o = req_wr_i;
                gnt_rd_o = req_rd_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            rr_last <= REQ_RD;
        end else if (gnt_wr_o) begin
            rr_last <= REQ_WR;
        end else if (gnt_rd_o) begin
            rr_last <= REQ_RD;
        end
    end

endmodule

// File: rtl/intra_ram_arb_ctl.sv
// ----------------------------------------------------------------------------
// intra_ram_arb_ctl
//   Port-A controller for the 32x64 dual-port intra RAM. Shares the port
//   between the reconstruction write-back (write) and the neighbour fetch
//   (read) with round-robin arbitration, one access per cycle, and runs a
//   clear sweep that writes CLR_VALUE to every address at CTU/tile start.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   clr_start_i / clr_busy_o     start pulse / sweep in progress
//   wr_req_i, wr_addr_i,         write request held with address and data
//   wr_data_i, wr_ack_o          until the combinational ack
//   rd_req_i, rd_addr_i,         read request held with address until the
//   rd_ack_o                     combinational ack
//   rd_valid_o, rd_data_o        read data, one cycle after rd_ack_o
//   ram_cen_o, ram_oen_o,        active-low RAM controls
//   ram_wen_o
//   ram_addr_o, ram_data_o       RAM address and write data
//   ram_data_i                   RAM read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module intra_ram_arb_ctl
    import intra_ram_arb_ctl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = INTRA_RAM_AW,
    parameter int                    WORD_WIDTH = INTRA_RAM_WW,
    parameter logic [WORD_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    output logic                  wr_ack_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_ack_o,
    output logic                  rd_valid_o,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_data_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    ctl_state_e            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] addr_q;   // address of the last access, held while idle
    logic [WORD_WIDTH-1:0] data_q;   // write data of the last access, held while idle
    logic                  serve_en;
    logic                  gnt_wr;
    logic                  gnt_rd;

    // The clear start cycle itself leaves the port idle; reset gates the
    // combinational acks so they read 0 while rst_n is low.
    assign serve_en = rst_n && (state == ST_SERVE) && !clr_start_i;

    intra_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (serve_en),
        .req_wr_i (wr_req_i),
        .req_rd_i (rd_req_i),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    assign wr_ack_o  = gnt_wr;
    assign rd_ack_o  = gnt_rd;
    assign ram_oen_o = 1'b0;

    // RAM port mux: clear sweep wins over everything, otherwise the granted
    // requester drives the port. Idle cycles keep the previous address/data.
    always_comb begin
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_addr_o = addr_q;
        ram_data_o = data_q;
        if (state == ST_CLEAR) begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = clr_cnt;
            ram_data_o = CLR_VALUE;
        end else if (gnt_wr) begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = wr_addr_i;
            ram_data_o = wr_data_i;
        end else if (gnt_rd) begin
            ram_cen_o  = 1'b0;
            ram_addr_o = rd_addr_i;
        end
    end

    // Controller FSM with the clear counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SERVE;
            clr_cnt    <= '0;
            clr_busy_o <= 1'b0;
        end else begin
            case (state)
                ST_SERVE: begin
                    if (clr_start_i) begin
                        state      <= ST_CLEAR;
                        clr_cnt    <= '0;
                        clr_busy_o <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CNT_LAST) begin
                        state      <= ST_SERVE;
                        clr_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_SERVE;
                    clr_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline and idle-hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            rd_pend <= gnt_rd;
            if (!ram_cen_o) begin
                addr_q <= ram_addr_o;
                data_q <= ram_data_o;
            end
        end
    end

    assign rd_valid_o = rd_pend;
    assign rd_data_o  = rd_pend ? ram_data_i : '0;

endmodule

// File: tb/tb_intra_ram_arb_ctl.sv
// ----------------------------------------------------------------------------
// tb_intra_ram_arb_ctl
//   Directed bench for intra_ram_arb_ctl with a behavioural 64x32 RAM on
//   port A. Inputs change 1 time unit after the rising edge and outputs are
//   sampled 1 time unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_intra_ram_arb_ctl;

    localparam int AW = 6;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_start_i;
    logic          clr_busy_o;
    logic          wr_req_i;
    logic [AW-1:0] wr_addr_i;
    logic [WW-1:0] wr_data_i;
    logic          wr_ack_o;
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_ack_o;
    logic          rd_valid_o;
    logic [WW-1:0] rd_data_o;
    logic          ram_cen_o;
    logic          ram_oen_o;
    logic          ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [WW-1:0] ram_data_o;
    logic [WW-1:0] ram_data_i;

    always #5 clk = ~clk;

    intra_ram_arb_ctl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_start_i (clr_start_i),
        .clr_busy_o  (clr_busy_o),
        .wr_req_i    (wr_req_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_ack_o    (wr_ack_o),
        .rd_req_i    (rd_req_i),
        .rd_addr_i   (rd_addr_i),
        .rd_ack_o    (rd_ack_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .ram_cen_o   (ram_cen_o),
        .ram_oen_o   (ram_oen_o),
        .ram_wen_o   (ram_wen_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i)
    );

    // Behavioural single-port view of the RAM: synchronous write, registered read.
    logic [WW-1:0] mem [64];
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) mem[ram_addr_o] <= ram_data_o;
            else            ram_data_i      <= mem[ram_addr_o];
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1 ({tag, "_wr_ack"},   wr_ack_o,   1'b0);
        check1 ({tag, "_rd_ack"},   rd_ack_o,   1'b0);
        check1 ({tag, "_rd_valid"}, rd_valid_o, 1'b0);
        check32({tag, "_rd_data"},  rd_data_o,  32'h0);
        check1 ({tag, "_busy"},     clr_busy_o, 1'b0);
        check1 ({tag, "_cen"},      ram_cen_o,  1'b1);
        check1 ({tag, "_wen"},      ram_wen_o,  1'b1);
        check1 ({tag, "_oen"},      ram_oen_o,  1'b0);
        check32({tag, "_addr"},     32'(ram_addr_o), 32'h0);
        check32({tag, "_data"},     ram_data_o, 32'h0);
    endtask

    logic [WW-1:0] wb [3];

    initial begin
        wb = '{32'h11, 32'h22, 32'h33};

        // ---- reset with both requests already asserted ----
        rst_n       = 1'b0;
        clr_start_i = 1'b0;
        wr_req_i    = 1'b1;
        wr_addr_i   = 6'd10;
        wr_data_i   = 32'hA0A0A0A0;
        rd_req_i    = 1'b1;
        rd_addr_i   = 6'd11;
        #2;
        check_reset_outputs("rst");
        step();
        step();

        // ---- dual held requests from reset: W,R,W,R,W,R ----
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check1("dual_wr_ack", wr_ack_o, (i % 2) == 0);
            check1("dual_rd_ack", rd_ack_o, (i % 2) == 1);
            check1("dual_one_ack", wr_ack_o & rd_ack_o, 1'b0);
            check1("dual_rd_valid", rd_valid_o, (i > 0) && ((i % 2) == 0));
            step();
        end
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        #1;
        check1("dual_last_valid", rd_valid_o, 1'b1);
        check1("dual_idle_cen", ram_cen_o, 1'b1);

        // ---- clear sweep ----
        step();
        clr_start_i = 1'b1;
        #1;
        check1("clr_start_cen", ram_cen_o, 1'b1);
        check1("clr_start_busy", clr_busy_o, 1'b0);
        step();
        clr_start_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            check1 ("clr_busy", clr_busy_o, 1'b1);
            check1 ("clr_cen",  ram_cen_o,  1'b0);
            check1 ("clr_wen",  ram_wen_o,  1'b0);
            check32("clr_addr", 32'(ram_addr_o), 32'(i));
            check32("clr_data", ram_data_o, 32'h0);
            step();
        end
        rd_req_i  = 1'b1;
        rd_addr_i = 6'd37;
        #1;
        check1 ("clr_done_busy", clr_busy_o, 1'b0);
        check1 ("rd37_ack", rd_ack_o, 1'b1);
        check1 ("rd37_cen", ram_cen_o, 1'b0);
        check1 ("rd37_wen", ram_wen_o, 1'b1);
        check32("rd37_addr", 32'(ram_addr_o), 32'd37);
        step();
        rd_req_i = 1'b0;
        #1;
        check1 ("rd37_valid", rd_valid_o, 1'b1);
        check32("rd37_data", rd_data_o, 32'h0);

        // ---- write then read of the same address ----
        step();
        wr_req_i  = 1'b1;
        wr_addr_i = 6'd5;
        wr_data_i = 32'hDEADBEEF;
        #1;
        check1 ("wr5_ack", wr_ack_o, 1'b1);
        check1 ("wr5_rd_ack", rd_ack_o, 1'b0);
        check1 ("wr5_wen", ram_wen_o, 1'b0);
        check32("wr5_addr", 32'(ram_addr_o), 32'd5);
        check32("wr5_data", ram_data_o, 32'hDEADBEEF);
        step();
        wr_req_i  = 1'b0;
        rd_req_i  = 1'b1;
        rd_addr_i = 6'd5;
        #1;
        check1 ("rd5_ack", rd_ack_o, 1'b1);
        check1 ("rd5_valid_early", rd_valid_o, 1'b0);
        check32("rd5_data_early", rd_data_o, 32'h0);
        step();
        rd_req_i = 1'b0;
        #1;
        check1 ("rd5_valid", rd_valid_o, 1'b1);
        check32("rd5_data", rd_data_o, 32'hDEADBEEF);
        check1 ("idle_cen", ram_cen_o, 1'b1);
        check32("idle_addr_hold", 32'(ram_addr_o), 32'd5);
        step();
        #1;
        check1 ("rd5_valid_drop", rd_valid_o, 1'b0);
        check32("rd5_data_drop", rd_data_o, 32'h0);

        // ---- back-to-back writes then back-to-back reads ----
        wr_req_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wr_addr_i = 6'(j);
            wr_data_i = wb[j];
            #1;
            check1("b2b_wr_ack", wr_ack_o, 1'b1);
            step();
        end
        wr_req_i = 1'b0;
        rd_req_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            rd_addr_i = 6'(j);
            #1;
            check1("b2b_rd_ack", rd_ack_o, 1'b1);
            check1("b2b_rd_valid", rd_valid_o, j > 0);
            if (j > 0) check32("b2b_rd_data", rd_data_o, wb[j-1]);
            step();
        end
        rd_req_i = 1'b0;
        #1;
        check1 ("b2b_rd_valid_last", rd_valid_o, 1'b1);
        check32("b2b_rd_data_last", rd_data_o, wb[2]);

        // ---- write request held during clear; restart pulse ignored ----
        step();
        clr_start_i = 1'b1;
        #1;
        step();
        clr_start_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                wr_req_i  = 1'b1;
                wr_addr_i = 6'd7;
                wr_data_i = 32'h00000077;
            end
            clr_start_i = (i == 30);
            #1;
            check1 ("hold_busy", clr_busy_o, 1'b1);
            check1 ("hold_wr_ack", wr_ack_o, 1'b0);
            check1 ("hold_wen", ram_wen_o, 1'b0);
            check32("hold_addr", 32'(ram_addr_o), 32'(i));
            check32("hold_data", ram_data_o, 32'h0);
            step();
        end
        clr_start_i = 1'b0;
        #1;
        check1 ("hold_end_busy", clr_busy_o, 1'b0);
        check1 ("hold_end_wr_ack", wr_ack_o, 1'b1);
        check32("hold_end_addr", 32'(ram_addr_o), 32'd7);
        check32("hold_end_data", ram_data_o, 32'h00000077);
        step();
        wr_req_i  = 1'b0;
        rd_req_i  = 1'b1;
        rd_addr_i = 6'd7;
        #1;
        check1("rd7_ack", rd_ack_o, 1'b1);
        step();
        rd_req_i = 1'b0;
        #1;
        check32("rd7_data", rd_data_o, 32'h00000077);

        // ---- reset in the middle of a clear sweep ----
        step();
        clr_start_i = 1'b1;
        #1;
        step();
        clr_start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check32("abort_addr", 32'(ram_addr_o), 32'(i));
            step();
        end
        rd_req_i  = 1'b1;
        rd_addr_i = 6'd3;
        #1;
        check1 ("abort_pre_busy", clr_busy_o, 1'b1);
        check1 ("abort_pre_rd_ack", rd_ack_o, 1'b0);
        check32("abort_pre_addr", 32'(ram_addr_o), 32'd20);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        step();
        step();
        rst_n = 1'b1;
        #1;
        check1 ("post_rst_busy", clr_busy_o, 1'b0);
        check1 ("post_rst_rd_ack", rd_ack_o, 1'b1);
        check1 ("post_rst_cen", ram_cen_o, 1'b0);
        check32("post_rst_addr", 32'(ram_addr_o), 32'd3);
        step();
        rd_req_i = 1'b0;
        #1;
        check1("post_rst_valid", rd_valid_o, 1'b1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
